// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared states and frame constants for the UART receive path
//   No ports. Provides rx_state_e, OVS_RATE, MID_SAMPLE, DATA_BITS.
package uart_pkg;

    localparam int OVS_RATE   = 16;   // oversample ticks per bit
    localparam int MID_SAMPLE = 7;    // tick index treated as the centre of the start bit
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core_if.sv
// rtl/uart_rx_core_if.sv - received-byte valid/ready stream between receiver and consumer
//   data_o  : byte at FIFO head        (master -> slave)
//   valid_o : FIFO non-empty           (master -> slave)
//   ready_i : consumer takes the byte  (slave -> master)
interface uart_rx_core_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data_o;
    logic                 valid_o;
    logic                 ready_i;

    modport master (output data_o, output valid_o, input ready_i);
    modport slave  (input data_o, input valid_o, output ready_i);

endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - small synchronous FIFO holding received bytes
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, push_data   : write request and byte (dropped when full unless popping)
//   pop               : read request (ignored when empty)
//   pop_data          : head byte; holds the last popped byte while empty
//   full, empty       : status from pointer comparison
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                last_q <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data = empty ? last_q : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 16x oversampling UART receiver with output FIFO
//   clk, rst_n    : clock, asynchronous active-low reset
//   rx_i          : serial line, idle high, asynchronous
//   out_if        : received bytes (data_o / valid_o / ready_i)
//   frame_err_o   : 1-cycle pulse, stop bit sampled low
//   parity_err_o  : 1-cycle pulse, even parity mismatch (0 unless UART_PARITY_EN)
//   overrun_o     : 1-cycle pulse, byte dropped because the FIFO was full
//   busy_o        : receiver FSM not idle
//   UART_PARITY_EN: when defined, frames carry an even parity bit after the data (8E1)
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int OVS_DIV    = 27,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_i,
    uart_rx_core_if.master   out_if,
    output logic             frame_err_o,
    output logic             parity_err_o,
    output logic             overrun_o,
    output logic             busy_o
);

    localparam int TW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [3:0]    MID      = 4'(MID_SAMPLE);
    localparam logic [3:0]    LAST     = 4'(OVS_RATE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 rx_meta, rx_s, rx_prev;
    logic [TW-1:0]        tick_cnt;
    logic [3:0]           ovs_cnt;
    logic                 tick, mid_tick, end_tick, fall;
    rx_state_e            state, state_nxt;
    logic                 cnt_clr, shift_en, stop_smp;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 push_q;
    logic                 fifo_full, fifo_empty, fifo_pop;
`ifdef UART_PARITY_EN
    logic                 par_smp;
    logic                 par_bad;
`endif

    // Synchroniser plus one history flop for edge detection; all reset to the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign fall     = rx_prev && !rx_s;
    assign tick     = (tick_cnt == TW'(OVS_DIV - 1));
    assign mid_tick = tick && (ovs_cnt == MID);
    assign end_tick = tick && (ovs_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            ovs_cnt  <= '0;
        end else if (cnt_clr) begin
            tick_cnt <= '0;
            ovs_cnt  <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            ovs_cnt  <= ovs_cnt + 4'd1;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        stop_smp  = 1'b0;
`ifdef UART_PARITY_EN
        par_smp   = 1'b0;
`endif
        case (state)
            IDLE: if (fall) begin
                cnt_clr   = 1'b1;
                state_nxt = START;
            end
            // A start bit that is already high again at its centre is a glitch.
            START: if (mid_tick) begin
                cnt_clr   = 1'b1;
                state_nxt = rx_s ? IDLE : DATA;
            end
            DATA: if (end_tick) begin
                shift_en = 1'b1;
`ifdef UART_PARITY_EN
                if (bit_idx == LAST_BIT) state_nxt = PARITY;
`else
                if (bit_idx == LAST_BIT) state_nxt = STOP;
`endif
            end
`ifdef UART_PARITY_EN
            PARITY: if (end_tick) begin
                par_smp   = 1'b1;
                state_nxt = STOP;
            end
`endif
            STOP: if (end_tick) begin
                stop_smp  = 1'b1;
                state_nxt = rx_s ? IDLE : WAIT_HIGH;
            end
            // A held-low line (break) must not be mistaken for a new start bit.
            WAIT_HIGH: if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx     <= '0;
            shreg       <= '0;
            push_q      <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad      <= 1'b0;
            parity_err_o <= 1'b0;
`endif
        end else begin
            if (cnt_clr) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                bit_idx <= bit_idx + BW'(1);
            end
            frame_err_o <= stop_smp && !rx_s;
            overrun_o   <= push_q && fifo_full && !fifo_pop;
`ifdef UART_PARITY_EN
            if (par_smp) par_bad <= ^{shreg, rx_s};
            parity_err_o <= stop_smp && par_bad;
            push_q       <= stop_smp && rx_s && !par_bad;
`else
            push_q       <= stop_smp && rx_s;
`endif
        end
    end

`ifndef UART_PARITY_EN
    assign parity_err_o = 1'b0;
`endif

    // shreg stays stable long after the stop sample, so it feeds the FIFO directly.
    assign fifo_pop = out_if.ready_i && !fifo_empty;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_q),
        .push_data (shreg),
        .pop       (fifo_pop),
        .pop_data  (out_if.data_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_if.valid_o = !fifo_empty;
    assign busy_o         = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - self-checking bench for uart_rx_core against a frame-level model
module tb_uart_rx_core;

    localparam int OVS_DIV    = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int BP         = 16 * OVS_DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx_i  = 1'b1;
    logic ready = 1'b0;
    logic frame_err, parity_err, overrun, busy;

    uart_rx_core_if rx_if ();
    assign rx_if.ready_i = ready;

    uart_rx_core #(
        .OVS_DIV    (OVS_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (rx_i),
        .out_if       (rx_if),
        .frame_err_o  (frame_err),
        .parity_err_o (parity_err),
        .overrun_o    (overrun),
        .busy_o       (busy)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observation side: cycle count, popped bytes, error pulse rises and high cycles.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got_q[$];
    int         rise[3];
    int         hi[3];
    logic [2:0] err_d = '0;
    logic       v_d = 1'b0;
    int unsigned v_rise_cyc = 0;

    always @(negedge clk) begin
        logic [2:0] e;
        e = {overrun, parity_err, frame_err};
        if (rst_n && rx_if.valid_o && ready) got_q.push_back(rx_if.data_o);
        for (int k = 0; k < 3; k++) begin
            if (e[k]) hi[k]++;
            if (e[k] && !err_d[k]) rise[k]++;
        end
        err_d = e;
        if (rx_if.valid_o && !v_d) v_rise_cyc = cyc;
        v_d = rx_if.valid_o;
    end

    // Reference model: expected delivered bytes and expected error pulse counts.
    logic [7:0] exp_q[$];
    int exp_err[3];     // 0 frame, 1 parity, 2 overrun
    int model_occ = 0;
    int unsigned start_cyc = 0;

    task automatic drive_bit(input logic b, input int n);
        rx_i = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input logic flip);
        logic bad_par;
        start_cyc = cyc;
        drive_bit(1'b0, BP);
        for (int i = 0; i < 8; i++) drive_bit(data[i], BP);
`ifdef UART_PARITY_EN
        drive_bit((^data) ^ flip, BP);
        bad_par = flip;
`else
        bad_par = 1'b0;
`endif
        drive_bit(stop, BP);
        if (!stop) exp_err[0]++;
        if (bad_par) exp_err[1]++;
        if (stop && !bad_par) begin
            if (!ready && model_occ == FIFO_DEPTH) begin
                exp_err[2]++;
            end else begin
                exp_q.push_back(data);
                if (!ready) model_occ++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
        check({tag, "_frame_err"}, rise[0], exp_err[0]);
        check({tag, "_parity_err"}, rise[1], exp_err[1]);
        check({tag, "_overrun"}, rise[2], exp_err[2]);
        check({tag, "_busy"}, busy, 1'b0);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, rx_if.data_o, 8'h00);
        check({tag, "_valid"}, rx_if.valid_o, 1'b0);
        check({tag, "_errs"}, {overrun, parity_err, frame_err}, 3'b000);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #(20 * 150000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        for (int k = 0; k < 3; k++) begin
            rise[k] = 0; hi[k] = 0; exp_err[k] = 0;
        end
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        drive_bit(1'b1, 2 * BP);

        // 1: single frame, latency from the start edge to valid_o
        ready = 1'b1;
        v_rise_cyc = 0;
        send_frame(8'hA5, 1'b1, 1'b0);
        check("t1_latency", v_rise_cyc - start_cyc, (BP * 19) / 2 + 4);
        drive_bit(1'b1, BP);
        check_all("t1");

        // 2: short low glitch is rejected at the start-bit centre
        drive_bit(1'b0, 100);
        check("t2_busy_during", busy, 1'b1);
        drive_bit(1'b1, 200);
        check("t2_valid", rx_if.valid_o, 1'b0);
        check_all("t2");

        // 3: framing error followed by a long break, then a good frame
        send_frame(8'h3C, 1'b0, 1'b0);
        drive_bit(1'b0, 5000);
        check("t3_busy_break", busy, 1'b1);
        drive_bit(1'b1, 2 * BP);
        send_frame(8'h55, 1'b1, 1'b0);
        drive_bit(1'b1, BP);
        check_all("t3");

        // 4: overrun with the consumer stalled
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
        drive_bit(1'b1, BP);
        check("t4_valid_full", rx_if.valid_o, 1'b1);
        ready = 1'b1;
        model_occ = 0;
        drive_bit(1'b1, 20);
        check("t4_valid_empty", rx_if.valid_o, 1'b0);
        check("t4_data_hold", rx_if.data_o, 8'h04);
        check_all("t4");

`ifdef UART_PARITY_EN
        // 5: wrong then correct even parity
        send_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0);
        drive_bit(1'b1, BP);
        check_all("t5");
`endif

        // 6: asynchronous reset in the middle of a frame with bytes queued
        ready = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        drive_bit(1'b1, BP);
        check("t6_valid_queued", rx_if.valid_o, 1'b1);
        d = 8'h96;
        drive_bit(1'b0, BP);
        for (int i = 0; i < 4; i++) drive_bit(d[i], BP);
        drive_bit(d[4], BP / 2);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("t6_reset");
        rx_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        model_occ = 0;
        ready = 1'b1;
        drive_bit(1'b1, 2 * BP);
        send_frame(8'hC3, 1'b1, 1'b0);
        drive_bit(1'b1, BP);
        check_all("t6");

        // Randomised frames with occasional framing and parity faults
        for (int n = 0; n < 6; n++) begin
            logic st, fl;
            d  = 8'($urandom);
            st = ($urandom_range(0, 4) != 0);
`ifdef UART_PARITY_EN
            fl = ($urandom_range(0, 3) == 0);
`else
            fl = 1'b0;
`endif
            send_frame(d, st, fl);
            drive_bit(1'b1, $urandom_range(4, BP));
        end
        drive_bit(1'b1, BP);
        check_all("rand");

        for (int k = 0; k < 3; k++)
            check($sformatf("pulse_width%0d", k), hi[k], rise[k]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Standalone UART receiver. Deserialises an 8N1 serial stream (8E1 with the optional feature) into bytes using 16x oversampling, and buffers received bytes in a small FIFO. Bytes leave through a valid/ready handshake. Sits on the serial input side of top_Uart and pairs with the existing transmit path on the same line format. Framing, parity and overrun conditions are reported as single-cycle pulses.

Parameters:
OVS_DIV, 27, clk cycles per oversample tick (50 MHz / (115200*16) rounded); bit period = 16*OVS_DIV cycles
FIFO_DEPTH, 4, receive FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock (50 MHz nominal, Tck = 20 ns)
rst_n  in  1  asynchronous active-low reset
rx_i  in  1  serial input, idle high, asynchronous to clk
data_o  out  8  FIFO head byte
valid_o  out  1  FIFO non-empty
ready_i  in  1  consumer accepts data_o when valid_o && ready_i
frame_err_o  out  1  1-cycle pulse: stop bit sampled low
parity_err_o  out  1  1-cycle pulse: parity mismatch (tied 0 without feature)
overrun_o  out  1  1-cycle pulse: byte dropped, FIFO full
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n=0): data_o=0, valid_o=0, all error outputs=0, busy_o=0; FIFO emptied, FSM=IDLE, counters=0. Synchroniser flops reset to 1.
- rx_i passes a 2-flop synchroniser; all logic uses rx_s.
- Tick counter: runs 0..OVS_DIV-1 and emits a tick at wrap. It is cleared when the falling edge is detected in IDLE.
- Oversample counter: 4 bits, advances on each tick.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP, WAIT_HIGH.
- IDLE: a falling edge on rx_s (1->0) moves to START and clears the counters.
- START: at tick 7 (mid-bit), rx_s=0 moves to DATA with bit index 0 and the counters cleared; rx_s=1 is a glitch, return to IDLE with no error.
- DATA: sample at each 16th tick, LSB first, into a shift register. After bit 7, go to PARITY if compiled in, else STOP.
- STOP, stop sample = 1: push the byte unless it is flagged for parity error; return to IDLE.
- STOP, stop sample = 0: pulse frame_err_o, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: remain until rx_s=1, then IDLE. Line-break low never retriggers.
- Push latency: byte is written the cycle after the stop sample; valid_o rises the following cycle.
- Push when FIFO full and no pop that cycle: drop the byte and pulse overrun_o; FIFO contents unchanged.
- Full with simultaneous pop and push: both succeed.
- Empty: ready_i is ignored; data_o holds the last value.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full/empty come from the MSB comparison.
- Error pulses last exactly 1 cycle each. Frame and parity errors on the same frame both pulse.

Optional Feature:
UART_PARITY_EN
- Defined: a PARITY state follows DATA and samples the 9th bit. Even parity is required (XOR of data and parity bits = 0). On mismatch, parity_err_o pulses in the STOP-sample cycle and the byte is discarded. Frame check still applies.
- Undefined: no PARITY state; parity_err_o is constant 0; frame is 10 bits.

Decomposition:
- Package uart_pkg holds: rx_state_e enum, OVS_RATE=16, MID_SAMPLE=7, DATA_BITS=8.
- One sub-module, uart_rx_fifo: synchronous FIFO parameterised on depth, with push/pop/full/empty ports.
- Tick generation and the FSM stay in uart_rx_core.

Test Plan:
1. Frame 0xA5 (8N1), ready_i=1 -> valid_o=1 with data_o=0xA5 about 9.5*432+4 cycles after the start edge; no error pulses; busy_o back to 0.
2. rx_i low for 100 cycles, then high -> no valid_o, no errors; busy_o returns to 0 at the tick-7 check.
3. Frame 0x3C with stop=0, rx held low 5000 cycles, then frame 0x55 -> one frame_err_o pulse with 0x3C discarded; then 0x55 received correctly.
4. ready_i=0, bytes 0x01..0x05 back-to-back -> overrun_o pulses once on 0x05; popping returns 0x01,0x02,0x03,0x04, then valid_o=0.
5. (UART_PARITY_EN) 0x07 with parity bit 0 -> parity_err_o pulse, byte dropped; 0x07 with parity bit 1 -> data_o=0x07.
6. rst_n pulled low during data bit 4 with 2 bytes queued -> all outputs 0 immediately; after release, frame 0xC3 -> data_o=0xC3 only.
